// File: rtl/uart_rx_block_assembler.sv
// 8N1 UART receiver (16x oversampled) that packs 16 good bytes into one 128-bit block
// and offers it downstream over valid/ready, with framing, timeout and overrun reporting.
`timescale 1ns/1ps
module uart_rx_block_assembler #(
    parameter int CLK_FREQ     = 50000000,
    parameter int BAUD_RATE    = 115200,
    parameter int TICK_DIV     = CLK_FREQ / (BAUD_RATE * 16),
    parameter int TIMEOUT_BITS = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rx,
    input  logic         block_ready,
    output logic [127:0] plaintext_out,
    output logic         block_valid,
    output logic [7:0]   rx_byte,
    output logic         rx_byte_valid,
    output logic [4:0]   byte_count,
    output logic         frame_err,
    output logic         timeout_err,
    output logic         overrun_err
);
    localparam int TDW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TO_LIMIT = TIMEOUT_BITS * 16;
    localparam int TOW      = $clog2(TO_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state;
    logic           rx_p0, rx_p1, rx_p2;
    logic [TDW-1:0] tick_cnt;
    logic [3:0]     bit_tick;
    logic [2:0]     bit_idx;
    logic [7:0]     shreg;
    logic [119:0]   asm_q;
    logic [TOW-1:0] to_cnt;
    logic           tick;
    logic           start_det;

    assign tick      = (tick_cnt == TDW'(TICK_DIV - 1));
    // rx_p1 is the synchronized line, rx_p2 its previous value for falling-edge detection
    assign start_det = (state == IDLE) && rx_p2 && !rx_p1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            rx_p0         <= 1'b1;
            rx_p1         <= 1'b1;
            rx_p2         <= 1'b1;
            tick_cnt      <= '0;
            bit_tick      <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            asm_q         <= '0;
            to_cnt        <= '0;
            plaintext_out <= '0;
            block_valid   <= 1'b0;
            rx_byte       <= '0;
            rx_byte_valid <= 1'b0;
            byte_count    <= '0;
            frame_err     <= 1'b0;
            timeout_err   <= 1'b0;
            overrun_err   <= 1'b0;
        end else begin
            rx_p0         <= rx;
            rx_p1         <= rx_p0;
            rx_p2         <= rx_p1;
            rx_byte_valid <= 1'b0;
            frame_err     <= 1'b0;
            timeout_err   <= 1'b0;
            overrun_err   <= 1'b0;

            if (block_valid && block_ready)
                block_valid <= 1'b0;

            if (start_det || tick)
                tick_cnt <= '0;
            else
                tick_cnt <= tick_cnt + TDW'(1);

            case (state)
                IDLE: begin
                    bit_tick <= '0;
                    bit_idx  <= '0;
                    if (start_det) begin
                        state  <= START;
                        to_cnt <= '0;
                    end else if (byte_count == 5'd0) begin
                        to_cnt <= '0;
                    end else if (tick) begin
                        if (to_cnt == TOW'(TO_LIMIT - 1)) begin
                            to_cnt      <= '0;
                            byte_count  <= '0;
                            timeout_err <= 1'b1;
                        end else begin
                            to_cnt <= to_cnt + TOW'(1);
                        end
                    end
                end
                START: begin
                    if (tick) begin
                        if (bit_tick == 4'd7) begin
                            bit_tick <= '0;
                            state    <= rx_p1 ? IDLE : DATA;
                        end else begin
                            bit_tick <= bit_tick + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_tick == 4'd15) begin
                            bit_tick <= '0;
                            shreg    <= {rx_p1, shreg[7:1]};
                            bit_idx  <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7)
                                state <= STOP;
                        end else begin
                            bit_tick <= bit_tick + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (bit_tick == 4'd15) begin
                            bit_tick <= '0;
                            state    <= IDLE;
                            if (rx_p1) begin
                                rx_byte       <= shreg;
                                rx_byte_valid <= 1'b1;
                                if (byte_count == 5'd15) begin
                                    byte_count <= '0;
                                    // A block accepted this very edge frees the output register
                                    if (!block_valid || block_ready) begin
                                        plaintext_out <= {asm_q, shreg};
                                        block_valid   <= 1'b1;
                                    end else begin
                                        overrun_err <= 1'b1;
                                    end
                                end else begin
                                    asm_q      <= {asm_q[111:0], shreg};
                                    byte_count <= byte_count + 5'd1;
                                end
                            end else begin
                                frame_err  <= 1'b1;
                                byte_count <= '0;
                            end
                        end else begin
                            bit_tick <= bit_tick + 4'd1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_block_assembler.sv
// Scoreboard bench for uart_rx_block_assembler: directed UART frames with queued expectations
// checked by an independent output monitor.
`timescale 1ns/1ps
module tb_uart_rx_block_assembler;
    localparam int BIT = 32;  // clocks per bit with TICK_DIV = 2

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         rx = 1'b1;
    logic         block_ready = 1'b1;
    logic [127:0] plaintext_out;
    logic         block_valid;
    logic [7:0]   rx_byte;
    logic         rx_byte_valid;
    logic [4:0]   byte_count;
    logic         frame_err, timeout_err, overrun_err;

    uart_rx_block_assembler #(
        .CLK_FREQ(3686400), .BAUD_RATE(115200), .TIMEOUT_BITS(32)
    ) dut (
        .clk(clk), .reset(reset), .rx(rx), .block_ready(block_ready),
        .plaintext_out(plaintext_out), .block_valid(block_valid),
        .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid), .byte_count(byte_count),
        .frame_err(frame_err), .timeout_err(timeout_err), .overrun_err(overrun_err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [7:0] b; logic [4:0] c; } exp_byte_t;
    exp_byte_t    byte_q[$];
    logic [127:0] blk_q[$];

    int n_cmp = 0, n_err = 0;
    int exp_cnt = 0;
    int n_bytes = 0, n_frame = 0, n_tout = 0, n_ovr = 0, n_vcyc = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Output monitor: pops expectations whenever the DUT presents data
    always @(negedge clk) begin
        if (int'(frame_err) + int'(timeout_err) + int'(overrun_err) > 1) begin
            n_cmp++; n_err++;
            $display("FAIL err_exclusive: got %b%b%b expected at most one", frame_err, timeout_err, overrun_err);
        end
        if (frame_err === 1'b1)   n_frame++;
        if (timeout_err === 1'b1) n_tout++;
        if (overrun_err === 1'b1) n_ovr++;
        if (block_valid === 1'b1) n_vcyc++;
        if (rx_byte_valid === 1'b1) begin
            n_bytes++;
            if (byte_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_byte: got %0h expected none", rx_byte);
            end else begin
                exp_byte_t e;
                e = byte_q.pop_front();
                check("rx_byte", 128'(rx_byte), 128'(e.b));
                check("byte_count", 128'(byte_count), 128'(e.c));
            end
        end
        if (block_valid === 1'b1 && block_ready === 1'b1) begin
            if (blk_q.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL unexpected_block: got %0h expected none", plaintext_out);
            end else begin
                check("plaintext_out", plaintext_out, blk_q.pop_front());
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        if (stop_ok) begin
            exp_cnt = (exp_cnt + 1) % 16;
            byte_q.push_back({b, 5'(exp_cnt)});
        end else begin
            exp_cnt = 0;
        end
        rx = 1'b0;
        cycles(BIT);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cycles(BIT);
        end
        rx = stop_ok;
        cycles(BIT);
        rx = 1'b1;
    endtask

    // ready_at_end raises block_ready in the cycle whose edge samples the 16th stop bit
    task automatic send_block(input logic [127:0] blk, input logic expect_load, input logic ready_at_end);
        if (expect_load) blk_q.push_back(blk);
        for (int i = 0; i < 15; i++) send_byte(blk[127-8*i -: 8], 1'b1);
        if (ready_at_end) begin
            fork
                send_byte(blk[7:0], 1'b1);
                begin
                    repeat (306) @(posedge clk);
                    #2 block_ready = 1'b1;
                end
            join
        end else begin
            send_byte(blk[7:0], 1'b1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] blk_a, blk_b, blk_c, blk_d;
        blk_a = 128'h0123456789ABCDEFFEDCBA9876543210;
        blk_b = 128'hA5A55A5AC3C33C3C0F0FF0F012345678;
        blk_c = 128'h11112222333344445555666677778888;
        blk_d = 128'hDEADBEEFCAFEF00D0BADC0DE8BADF00D;

        // Reset state
        cycles(3);
        check("rst_plaintext", plaintext_out, 128'h0);
        check("rst_rx_byte", 128'(rx_byte), 128'h0);
        check("rst_flags", 128'({block_valid, rx_byte_valid, frame_err, timeout_err, overrun_err}), 128'h0);
        check("rst_byte_count", 128'(byte_count), 128'h0);
        reset = 1'b1;
        cycles(BIT);

        // 1: ascending byte pattern forms one block
        n_bytes = 0; n_vcyc = 0;
        send_block(128'h00112233445566778899AABBCCDDEEFF, 1'b1, 1'b0);
        cycles(4);
        check("t1_byte_pulses", 128'(n_bytes), 128'd16);
        check("t1_valid_cycles", 128'(n_vcyc), 128'd1);
        check("t1_byte_count", 128'(byte_count), 128'd0);

        // 2: framing error on byte 5 discards the partial block
        for (int i = 0; i < 4; i++) send_byte(8'(8'h20 + i), 1'b1);
        send_byte(8'h55, 1'b0);
        cycles(BIT);
        check("t2_frame_err", 128'(n_frame), 128'd1);
        check("t2_byte_count", 128'(byte_count), 128'd0);
        send_block(128'h102132435465768798A9BACBDCEDFE0F, 1'b1, 1'b0);
        cycles(4);
        check("t2_frame_err_after", 128'(n_frame), 128'd1);

        // 3: 3-tick low glitch is ignored silently
        n_bytes = 0;
        rx = 1'b0; cycles(6);
        rx = 1'b1; cycles(2 * BIT);
        check("t3_no_byte", 128'(n_bytes), 128'd0);
        check("t3_no_err", 128'(n_frame + n_tout + n_ovr), 128'd1);
        check("t3_byte_count", 128'(byte_count), 128'd0);

        // 4: inter-byte timeout after 32 idle bit-times
        for (int i = 0; i < 5; i++) send_byte(8'(8'hC0 + i), 1'b1);
        cycles(28 * BIT);
        check("t4_no_timeout_yet", 128'(n_tout), 128'd0);
        check("t4_count_held", 128'(byte_count), 128'd5);
        cycles(12 * BIT);
        exp_cnt = 0;
        check("t4_timeout_once", 128'(n_tout), 128'd1);
        check("t4_count_cleared", 128'(byte_count), 128'd0);
        send_block(128'hD30216C83D902E5090291C9D378FFC08, 1'b1, 1'b0);
        cycles(4);

        // 5: overrun while a block is pending, then simultaneous accept and reload
        block_ready = 1'b0;
        send_block(blk_a, 1'b1, 1'b0);
        check("t5_held_valid", 128'(block_valid), 128'd1);
        send_block(blk_b, 1'b0, 1'b0);
        check("t5_overrun", 128'(n_ovr), 128'd1);
        check("t5_data_stable", plaintext_out, blk_a);
        block_ready = 1'b1;
        cycles(2);
        check("t5_accepted", 128'(block_valid), 128'd0);
        block_ready = 1'b0;
        send_block(blk_c, 1'b1, 1'b0);
        check("t5_c_loaded", 128'(block_valid), 128'd1);
        send_block(blk_d, 1'b1, 1'b1);
        cycles(3);
        check("t5_no_second_overrun", 128'(n_ovr), 128'd1);
        check("t5_drained", 128'(block_valid), 128'd0);

        // 6: reset in the middle of byte 9
        for (int i = 0; i < 8; i++) send_byte(8'(8'h90 + i), 1'b1);
        rx = 1'b0; cycles(BIT);
        rx = 1'b1; cycles(3 * BIT + BIT / 2);
        reset = 1'b0;
        cycles(1);
        exp_cnt = 0;
        check("t6_plaintext", plaintext_out, 128'h0);
        check("t6_rx_byte", 128'(rx_byte), 128'h0);
        check("t6_flags", 128'({block_valid, rx_byte_valid, frame_err, timeout_err, overrun_err}), 128'h0);
        check("t6_byte_count", 128'(byte_count), 128'h0);
        cycles(2);
        reset = 1'b1;
        cycles(2 * BIT);
        send_block(128'hF0E1D2C3B4A5968778695A4B3C2D1E0F, 1'b1, 1'b0);
        cycles(8);

        check("end_bytes_drained", 128'(byte_q.size()), 128'd0);
        check("end_blocks_drained", 128'(blk_q.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
